prco_alu_seq: RTL and testbench

Parametrised, handshaked successor to the PRCO single-cycle ALU. It sits between decode and the register/RAM write-back stage. It executes single-cycle ops in one cycle, and runs MUL and barrel-free shifts as multi-cycle iterative ops. It keeps a full Z/S/O/C status register that drives every JMP/SET condition code.

---
 rtl/prco_alu_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_prco_alu_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/prco_alu_seq.sv
// PRCO handshaked ALU: single-cycle ops at one per cycle, iterative MUL and
// shifts, and a Z/S/O/C status register feeding the JMP/SET condition codes.
module prco_alu_seq #(
  parameter int DATA_W         = 16,
  parameter int IMM_W          = 8,
  parameter int SIMM_W         = 5,
  parameter int FLAGS_ON_ARITH = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              q_ready,
  input  logic              i_dec_req_ram,
  input  logic [4:0]        i_op,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_datb,
  input  logic [IMM_W-1:0]  i_imm,
  input  logic [SIMM_W-1:0] i_simm,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_result,
  output logic              q_should_branch,
  output logic              q_ce_reg,
  output logic              q_ce_ram,
  output logic [3:0]        q_flags
);

  localparam logic [4:0] OP_NOP  = 5'd0,  OP_MOV  = 5'd1,  OP_MOVI = 5'd2,
                         OP_ADD  = 5'd3,  OP_ADDI = 5'd4,  OP_SUB  = 5'd5,
                         OP_SUBI = 5'd6,  OP_CMP  = 5'd7,  OP_JMP  = 5'd8,
                         OP_SET  = 5'd9,  OP_LW   = 5'd10, OP_SW   = 5'd11,
                         OP_AND  = 5'd12, OP_OR   = 5'd13, OP_XOR  = 5'd14,
                         OP_MUL  = 5'd15, OP_SHL  = 5'd16, OP_SHR  = 5'd17;

  localparam logic [3:0] CC_J  = 4'd0, CC_JE  = 4'd1, CC_JNE = 4'd2,
                         CC_JS = 4'd3, CC_JNS = 4'd4, CC_JG  = 4'd5,
                         CC_JGE = 4'd6, CC_JL = 4'd7, CC_JLE = 4'd8;

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = SH_W + 1;
  localparam int MSB   = DATA_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_SHIFT} state_t;

  state_t state_q, state_d;

  // Execute-stage operand latch; ex_vld marks an op ready to retire next edge.
  logic              ex_vld;
  logic [4:0]        ex_op;
  logic [DATA_W-1:0] ex_a, ex_b;
  logic [IMM_W-1:0]  ex_imm;
  logic [SIMM_W-1:0] ex_simm;
  logic              ex_ram;

  logic [DATA_W-1:0] acc, mcand, mplier;
  logic [CNT_W-1:0]  cnt;

  logic              accept, is_shift, iter_last;
  logic [CNT_W-1:0]  shamt;

  assign q_ready   = (state_q == S_IDLE);
  assign accept    = i_valid & q_ready;
  assign is_shift  = (i_op == OP_SHL) || (i_op == OP_SHR);
  assign shamt     = {1'b0, i_datb[SH_W-1:0]};
  assign iter_last = (cnt == CNT_W'(1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) begin
        if (i_op == OP_MUL)                  state_d = S_MUL;
        else if (is_shift && shamt != '0)    state_d = S_SHIFT;
      end
      S_MUL, S_SHIFT: if (iter_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ex_vld  <= 1'b0;
      ex_op   <= '0;
      ex_a    <= '0;
      ex_b    <= '0;
      ex_imm  <= '0;
      ex_simm <= '0;
      ex_ram  <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
    end else if (accept) begin
      ex_op   <= i_op;
      ex_a    <= i_data;
      ex_b    <= i_datb;
      ex_imm  <= i_imm;
      ex_simm <= i_simm;
      ex_ram  <= i_dec_req_ram;
      mcand   <= i_data;
      mplier  <= i_datb;
      if (i_op == OP_MUL) begin
        ex_vld <= 1'b0;
        acc    <= '0;
        cnt    <= CNT_W'(DATA_W);
      end else if (is_shift && shamt != '0) begin
        ex_vld <= 1'b0;
        acc    <= i_data;
        cnt    <= shamt;
      end else begin
        // Zero-amount shifts retire straight away with acc = a.
        ex_vld <= 1'b1;
        acc    <= i_data;
        cnt    <= '0;
      end
    end else if (state_q == S_MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_W'(1);
      ex_vld <= iter_last;
    end else if (state_q == S_SHIFT) begin
      acc    <= (ex_op == OP_SHL) ? (acc << 1) : (acc >> 1);
      cnt    <= cnt - CNT_W'(1);
      ex_vld <= iter_last;
    end else begin
      ex_vld <= 1'b0;
    end
  end

  logic [DATA_W-1:0] imm_s, imm_z, simm_s, opd_b, res;
  logic [DATA_W:0]   sum, diff;
  logic [3:0]        add_flags, sub_flags, nflags;
  logic              upd, wr, br, cond;
  logic              fz, fs, fo;

  assign imm_s  = {{(DATA_W-IMM_W){ex_imm[IMM_W-1]}}, ex_imm};
  assign imm_z  = {{(DATA_W-IMM_W){1'b0}}, ex_imm};
  assign simm_s = {{(DATA_W-SIMM_W){ex_simm[SIMM_W-1]}}, ex_simm};
  assign opd_b  = (ex_op == OP_ADDI || ex_op == OP_SUBI) ? imm_s : ex_b;
  assign sum    = {1'b0, ex_a} + {1'b0, opd_b};
  assign diff   = {1'b0, ex_a} - {1'b0, opd_b};

  // {C,O,S,Z}; for subtraction the top bit of diff is the unsigned borrow.
  assign add_flags = {sum[DATA_W],
                      (ex_a[MSB] == opd_b[MSB]) & (sum[MSB] != ex_a[MSB]),
                      sum[MSB], (sum[MSB:0] == '0)};
  assign sub_flags = {diff[DATA_W],
                      (ex_a[MSB] != opd_b[MSB]) & (diff[MSB] != ex_a[MSB]),
                      diff[MSB], (diff[MSB:0] == '0)};

  assign fz = q_flags[0];
  assign fs = q_flags[1];
  assign fo = q_flags[2];

  always_comb begin
    cond = 1'b0;
    case (ex_imm[3:0])
      CC_J:    cond = 1'b1;
      CC_JE:   cond = fz;
      CC_JNE:  cond = ~fz;
      CC_JS:   cond = fs;
      CC_JNS:  cond = ~fs;
      CC_JG:   cond = ~fz & (fs == fo);
      CC_JGE:  cond = (fs == fo);
      CC_JL:   cond = (fs != fo);
      CC_JLE:  cond = fz | (fs != fo);
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    res    = '0;
    nflags = q_flags;
    upd    = 1'b0;
    wr     = 1'b0;
    br     = 1'b0;
    case (ex_op)
      OP_MOV:  begin res = ex_b;  wr = 1'b1; end
      OP_MOVI: begin res = imm_z; wr = 1'b1; end
      OP_ADD, OP_ADDI: begin
        res = sum[MSB:0]; wr = 1'b1;
        upd = (FLAGS_ON_ARITH != 0); nflags = add_flags;
      end
      OP_SUB, OP_SUBI: begin
        res = diff[MSB:0]; wr = 1'b1;
        upd = (FLAGS_ON_ARITH != 0); nflags = sub_flags;
      end
      OP_CMP:  begin upd = 1'b1; nflags = sub_flags; end
      OP_AND:  begin res = ex_a & ex_b; wr = 1'b1; end
      OP_OR:   begin res = ex_a | ex_b; wr = 1'b1; end
      OP_XOR:  begin res = ex_a ^ ex_b; wr = 1'b1; end
      OP_LW:   begin res = ex_b + simm_s; wr = 1'b1; end
      OP_SW:   res = ex_b + simm_s;
      OP_MUL, OP_SHL, OP_SHR: begin res = acc; wr = 1'b1; end
      OP_JMP:  begin res = ex_a; br = cond; end
      OP_SET:  begin res = {{(DATA_W-1){1'b0}}, cond}; wr = 1'b1; end
      default: res = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      q_valid         <= 1'b0;
      q_result        <= '0;
      q_should_branch <= 1'b0;
      q_ce_reg        <= 1'b0;
      q_ce_ram        <= 1'b0;
      q_flags         <= '0;
    end else begin
      q_valid         <= ex_vld;
      q_should_branch <= ex_vld & br;
      q_ce_reg        <= ex_vld & ~ex_ram & wr;
      q_ce_ram        <= ex_vld & ex_ram;
      if (ex_vld)       q_result <= res;
      if (ex_vld & upd) q_flags  <= nflags;
    end
  end

endmodule

// File: tb/tb_prco_alu_seq.sv
// Directed-vector bench for prco_alu_seq with hand-computed expectations.
module tb_prco_alu_seq;

  localparam logic [4:0] OP_NOP  = 5'd0,  OP_MOV  = 5'd1,  OP_MOVI = 5'd2,
                         OP_ADD  = 5'd3,  OP_ADDI = 5'd4,  OP_SUB  = 5'd5,
                         OP_SUBI = 5'd6,  OP_CMP  = 5'd7,  OP_JMP  = 5'd8,
                         OP_SET  = 5'd9,  OP_LW   = 5'd10, OP_SW   = 5'd11,
                         OP_AND  = 5'd12, OP_OR   = 5'd13, OP_XOR  = 5'd14,
                         OP_MUL  = 5'd15, OP_SHL  = 5'd16, OP_SHR  = 5'd17;
  localparam logic [7:0] CC_JE = 8'd1, CC_JGE = 8'd6, CC_JL = 8'd7;

  logic        i_clk = 1'b0, i_reset = 1'b1, i_valid = 1'b0, i_dec_req_ram = 1'b0;
  logic [4:0]  i_op = '0;
  logic [15:0] i_data = '0, i_datb = '0;
  logic [7:0]  i_imm = '0;
  logic [4:0]  i_simm = '0;
  logic        q_ready, q_valid, q_should_branch, q_ce_reg, q_ce_ram;
  logic [15:0] q_result;
  logic [3:0]  q_flags;

  int checks = 0, errors = 0;

  prco_alu_seq dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .q_ready(q_ready),
    .i_dec_req_ram(i_dec_req_ram), .i_op(i_op), .i_data(i_data), .i_datb(i_datb),
    .i_imm(i_imm), .i_simm(i_simm), .q_valid(q_valid), .q_result(q_result),
    .q_should_branch(q_should_branch), .q_ce_reg(q_ce_reg), .q_ce_ram(q_ce_ram),
    .q_flags(q_flags)
  );

  always #5 i_clk = ~i_clk;

  task automatic set_in(input logic [4:0] op, input logic [15:0] a, b,
                        input logic [7:0] imm, input logic [4:0] simm, input logic ram);
    i_op = op; i_data = a; i_datb = b; i_imm = imm; i_simm = simm; i_dec_req_ram = ram;
  endtask

  // Issue one op and wait (bounded) for its q_valid; lat = edges after accept, -1 on timeout.
  task automatic run_op(input logic [4:0] op, input logic [15:0] a, b,
                        input logic [7:0] imm, input logic [4:0] simm, input logic ram,
                        output int lat);
    set_in(op, a, b, imm, simm, ram);
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge i_clk); #1;
      if (q_valid) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({q_valid, q_should_branch, q_ce_reg, q_ce_ram, q_result, q_flags} !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0",
        {q_valid, q_should_branch, q_ce_reg, q_ce_ram, q_result, q_flags});
    end
    checks++;
    if (q_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", q_ready); end
    @(posedge i_clk); #1; @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_add_flags;
    int lat;
    run_op(OP_ADD, 16'h7FFF, 16'h0001, 8'h00, 5'h00, 1'b0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_lat: got %0d want 1", lat); end
    checks++; if (q_result !== 16'h8000) begin errors++; $display("FAIL add_result: got %h want 8000", q_result); end
    checks++; if (q_flags !== 4'b0110) begin errors++; $display("FAIL add_flags: got %b want 0110", q_flags); end
    checks++; if (q_ce_reg !== 1'b1 || q_ce_ram !== 1'b0) begin
      errors++; $display("FAIL add_ce: got reg=%b ram=%b want 1 0", q_ce_reg, q_ce_ram); end
    @(posedge i_clk); #1;
    checks++; if (q_valid !== 1'b0 || q_ce_reg !== 1'b0) begin
      errors++; $display("FAIL add_pulse: got v=%b ce=%b want 0 0", q_valid, q_ce_reg); end
    checks++; if (q_result !== 16'h8000) begin errors++; $display("FAIL add_hold: got %h want 8000", q_result); end
    // 0x0010 + sext(0xFF) = 0x000F with carry out, no signed overflow
    run_op(OP_ADDI, 16'h0010, 16'h0000, 8'hFF, 5'h00, 1'b0, lat);
    checks++; if (q_result !== 16'h000F || q_flags !== 4'b1000) begin
      errors++; $display("FAIL addi: got %h/%b want 000f/1000", q_result, q_flags); end
    // 0 - sext(1) = 0xFFFF with borrow
    run_op(OP_SUBI, 16'h0000, 16'h0000, 8'h01, 5'h00, 1'b0, lat);
    checks++; if (q_result !== 16'hFFFF || q_flags !== 4'b1010) begin
      errors++; $display("FAIL subi: got %h/%b want ffff/1010", q_result, q_flags); end
  endtask

  task automatic test_logic;
    int lat;
    run_op(OP_AND, 16'hF0F0, 16'hFF00, 8'h00, 5'h00, 1'b0, lat);
    checks++; if (q_result !== 16'hF000) begin errors++; $display("FAIL and: got %h want f000", q_result); end
    run_op(OP_OR, 16'hF0F0, 16'hFF00, 8'h00, 5'h00, 1'b0, lat);
    checks++; if (q_result !== 16'hFFF0) begin errors++; $display("FAIL or: got %h want fff0", q_result); end
    run_op(OP_XOR, 16'hF0F0, 16'hFF00, 8'h00, 5'h00, 1'b0, lat);
    checks++; if (q_result !== 16'h0FF0) begin errors++; $display("FAIL xor: got %h want 0ff0", q_result); end
    run_op(OP_MOVI, 16'h1234, 16'h5678, 8'h80, 5'h00, 1'b0, lat);
    checks++; if (q_result !== 16'h0080) begin errors++; $display("FAIL movi: got %h want 0080", q_result); end
    run_op(OP_NOP, 16'h1234, 16'h5678, 8'h00, 5'h00, 1'b0, lat);
    checks++; if (q_result !== 16'h0000 || q_ce_reg !== 1'b0 || q_should_branch !== 1'b0) begin
      errors++; $display("FAIL nop: got %h ce=%b br=%b want 0000 0 0", q_result, q_ce_reg, q_should_branch); end
  endtask

  task automatic test_cmp_jmp;
    int lat;
    run_op(OP_CMP, 16'h0005, 16'h0007, 8'h00, 5'h00, 1'b0, lat);
    checks++; if (q_flags !== 4'b1010) begin errors++; $display("FAIL cmp_flags: got %b want 1010", q_flags); end
    checks++; if (q_result !== 16'h0000 || q_ce_reg !== 1'b0) begin
      errors++; $display("FAIL cmp_result: got %h ce=%b want 0000 0", q_result, q_ce_reg); end
    run_op(OP_JMP, 16'h0040, 16'h0000, CC_JL, 5'h00, 1'b0, lat);
    checks++; if (q_result !== 16'h0040 || q_should_branch !== 1'b1 || q_ce_reg !== 1'b0) begin
      errors++; $display("FAIL jmp_jl: got %h br=%b ce=%b want 0040 1 0", q_result, q_should_branch, q_ce_reg); end
    run_op(OP_JMP, 16'h0040, 16'h0000, CC_JGE, 5'h00, 1'b0, lat);
    checks++; if (q_should_branch !== 1'b0) begin errors++; $display("FAIL jmp_jge: got %b want 0", q_should_branch); end
    run_op(OP_SET, 16'h0040, 16'h0000, CC_JL, 5'h00, 1'b0, lat);
    checks++; if (q_result !== 16'h0001 || q_should_branch !== 1'b0 || q_ce_reg !== 1'b1) begin
      errors++; $display("FAIL set_jl: got %h br=%b ce=%b want 0001 0 1", q_result, q_should_branch, q_ce_reg); end
  endtask

  task automatic test_back_to_back;
    set_in(OP_CMP, 16'h0007, 16'h0007, 8'h00, 5'h00, 1'b0);
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    set_in(OP_JMP, 16'h1234, 16'h0000, CC_JE, 5'h00, 1'b0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    checks++; if (q_valid !== 1'b1 || q_flags !== 4'b0001) begin
      errors++; $display("FAIL b2b_cmp: got v=%b f=%b want 1 0001", q_valid, q_flags); end
    @(posedge i_clk); #1;
    checks++; if (q_valid !== 1'b1 || q_result !== 16'h1234 || q_should_branch !== 1'b1) begin
      errors++; $display("FAIL b2b_jmp: got v=%b %h br=%b want 1 1234 1", q_valid, q_result, q_should_branch); end
    @(posedge i_clk); #1;
    checks++; if (q_valid !== 1'b0 || q_should_branch !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got v=%b br=%b want 0 0", q_valid, q_should_branch); end
  endtask

  task automatic test_mul;
    int lat, busy_bad, vld_bad;
    busy_bad = 0; vld_bad = 0;
    set_in(OP_MUL, 16'd300, 16'hFFFE, 8'h00, 5'h00, 1'b0);
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (q_ready !== 1'b0) busy_bad++;
      if (q_valid !== 1'b0) vld_bad++;
      if (k == 5) begin set_in(OP_ADD, 16'h1111, 16'h2222, 8'h00, 5'h00, 1'b0); i_valid = 1'b1; end
      if (k == 6) i_valid = 1'b0;
      @(posedge i_clk); #1;
    end
    checks++; if (busy_bad !== 0) begin errors++; $display("FAIL mul_busy: got %0d ready cycles want 0", busy_bad); end
    checks++; if (vld_bad !== 0 || q_valid !== 1'b0) begin
      errors++; $display("FAIL mul_early: got %0d early strobes want 0", vld_bad); end
    @(posedge i_clk); #1;
    checks++; if (q_valid !== 1'b1 || q_result !== 16'hFDA8 || q_ce_reg !== 1'b1) begin
      errors++; $display("FAIL mul_result: got v=%b %h ce=%b want 1 fda8 1", q_valid, q_result, q_ce_reg); end
    @(posedge i_clk); #1;
    checks++; if (q_valid !== 1'b0) begin errors++; $display("FAIL mul_ignored: got v=%b want 0", q_valid); end
    run_op(OP_MUL, 16'h00FF, 16'h0101, 8'h00, 5'h00, 1'b0, lat);
    checks++; if (lat !== 17 || q_result !== 16'hFFFF) begin
      errors++; $display("FAIL mul2: got lat=%0d %h want 17 ffff", lat, q_result); end
  endtask

  task automatic test_shift;
    int lat;
    run_op(OP_SHL, 16'h0003, 16'h0004, 8'h00, 5'h00, 1'b0, lat);
    checks++; if (lat !== 5 || q_result !== 16'h0030) begin
      errors++; $display("FAIL shl4: got lat=%0d %h want 5 0030", lat, q_result); end
    run_op(OP_SHR, 16'h8000, 16'h000F, 8'h00, 5'h00, 1'b0, lat);
    checks++; if (lat !== 16 || q_result !== 16'h0001) begin
      errors++; $display("FAIL shr15: got lat=%0d %h want 16 0001", lat, q_result); end
    run_op(OP_SHL, 16'hABCD, 16'h0000, 8'h00, 5'h00, 1'b0, lat);
    checks++; if (lat !== 1 || q_result !== 16'hABCD) begin
      errors++; $display("FAIL shl0: got lat=%0d %h want 1 abcd", lat, q_result); end
    run_op(OP_SHR, 16'h00F0, 16'h0013, 8'h00, 5'h00, 1'b0, lat);
    checks++; if (lat !== 4 || q_result !== 16'h001E) begin
      errors++; $display("FAIL shr_mask: got lat=%0d %h want 4 001e", lat, q_result); end
  endtask

  task automatic test_mem;
    int lat;
    run_op(OP_SW, 16'h0000, 16'h0100, 8'h00, 5'h1E, 1'b1, lat);
    checks++; if (q_result !== 16'h00FE || q_ce_ram !== 1'b1 || q_ce_reg !== 1'b0) begin
      errors++; $display("FAIL sw: got %h ram=%b reg=%b want 00fe 1 0", q_result, q_ce_ram, q_ce_reg); end
    run_op(OP_LW, 16'h0000, 16'h0010, 8'h00, 5'h0F, 1'b0, lat);
    checks++; if (q_result !== 16'h001F || q_ce_ram !== 1'b0 || q_ce_reg !== 1'b1) begin
      errors++; $display("FAIL lw: got %h ram=%b reg=%b want 001f 0 1", q_result, q_ce_ram, q_ce_reg); end
  endtask

  task automatic test_reset_mid_mul;
    int lat, stray;
    stray = 0;
    run_op(OP_CMP, 16'h0005, 16'h0007, 8'h00, 5'h00, 1'b0, lat);
    set_in(OP_MUL, 16'd300, 16'hFFFE, 8'h00, 5'h00, 1'b0);
    i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin @(posedge i_clk); #1; end
    i_reset = 1'b1;
    #1;
    checks++;
    if ({q_valid, q_should_branch, q_ce_reg, q_ce_ram, q_result, q_flags} !== '0 || q_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid: got %h rdy=%b want 0 1",
        {q_valid, q_should_branch, q_ce_reg, q_ce_ram, q_result, q_flags}, q_ready); end
    @(negedge i_clk);
    i_reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge i_clk); #1;
      if (q_valid !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rst_stray: got %0d strobes want 0", stray); end
    run_op(OP_ADD, 16'h0002, 16'h0003, 8'h00, 5'h00, 1'b0, lat);
    checks++; if (lat !== 1 || q_result !== 16'h0005 || q_flags !== 4'b0000) begin
      errors++; $display("FAIL rst_add: got lat=%0d %h f=%b want 1 0005 0000", lat, q_result, q_flags); end
  endtask

  initial begin
    test_reset;
    test_add_flags;
    test_logic;
    test_cmp_jmp;
    test_back_to_back;
    test_mul;
    test_shift;
    test_mem;
    test_reset_mid_mul;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
